// File: rtl/reorder_buffer.sv
// In-order retirement buffer: dual dispatch, dual completion, dual commit with freed-register mask.
// Latency: done set at edge T -> commit outputs valid after edge T+1; dispatch_ready is registered.
// Backpressure: dispatch_ready drops when fewer than 2 entries remain; valids presented while low are ignored.
module reorder_buffer #(
  parameter int ROB_DEPTH              = 16,
  parameter int NUM_PHYSICAL_REGISTERS = 64,
  localparam int IW = $clog2(ROB_DEPTH),
  localparam int CW = IW + 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              flush,
  input  logic                              dispatch1_valid,
  input  logic [4:0]                        dispatch1_rd,
  input  logic [5:0]                        dispatch1_p_rd,
  input  logic [5:0]                        dispatch1_p_old_rd,
  input  logic                              dispatch2_valid,
  input  logic [4:0]                        dispatch2_rd,
  input  logic [5:0]                        dispatch2_p_rd,
  input  logic [5:0]                        dispatch2_p_old_rd,
  output logic                              dispatch_ready,
  output logic [IW-1:0]                     dispatch1_rob_idx,
  output logic [IW-1:0]                     dispatch2_rob_idx,
  input  logic                              complete1_valid,
  input  logic [IW-1:0]                     complete1_rob_idx,
  input  logic                              complete2_valid,
  input  logic [IW-1:0]                     complete2_rob_idx,
  output logic                              commit1_valid,
  output logic [4:0]                        commit1_rd,
  output logic [5:0]                        commit1_p_rd,
  output logic [5:0]                        commit1_p_old_rd,
  output logic                              commit2_valid,
  output logic [4:0]                        commit2_rd,
  output logic [5:0]                        commit2_p_rd,
  output logic [5:0]                        commit2_p_old_rd,
  output logic [NUM_PHYSICAL_REGISTERS-1:0] freed_mask,
  output logic [CW-1:0]                     count
);

  localparam logic [CW-1:0] READY_MAX = CW'(ROB_DEPTH - 2);

  logic [IW-1:0] head, tail;
  logic          ent_vld      [ROB_DEPTH];
  logic          ent_done     [ROB_DEPTH];
  logic [4:0]    ent_rd       [ROB_DEPTH];
  logic [5:0]    ent_p_rd     [ROB_DEPTH];
  logic [5:0]    ent_p_old_rd [ROB_DEPTH];

  logic [IW-1:0] head_nx1, tail_nx1;
  logic          acc1, acc2, ret1, ret2;
  logic [1:0]    num_acc, num_ret;
  logic [CW-1:0] count_nxt;
  logic [NUM_PHYSICAL_REGISTERS-1:0] freed_nxt;

  // Slot assignment, retire decision on start-of-cycle state, and occupancy bookkeeping.
  always_comb begin
    head_nx1          = head + IW'(1);
    tail_nx1          = tail + IW'(1);
    acc1              = dispatch_ready & dispatch1_valid;
    acc2              = dispatch_ready & dispatch2_valid;
    // A lone instr2 packs into the tail slot so allocation stays contiguous.
    dispatch1_rob_idx = tail;
    dispatch2_rob_idx = dispatch1_valid ? tail_nx1 : tail;
    ret1              = ent_vld[head] & ent_done[head];
    ret2              = ret1 & ent_vld[head_nx1] & ent_done[head_nx1];
    num_acc           = {1'b0, acc1} + {1'b0, acc2};
    num_ret           = {1'b0, ret1} + {1'b0, ret2};
    count_nxt         = count + CW'(num_acc) - CW'(num_ret);
    freed_nxt         = '0;
    // rd=0 never owned a physical register, so nothing is released for it.
    if (ret1 && ent_rd[head] != 5'd0)     freed_nxt[ent_p_old_rd[head]]     = 1'b1;
    if (ret2 && ent_rd[head_nx1] != 5'd0) freed_nxt[ent_p_old_rd[head_nx1]] = 1'b1;
  end

  // Entry array, pointers, occupancy and registered commit outputs; reset and flush both empty the buffer.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        ent_vld[i]  <= 1'b0;
        ent_done[i] <= 1'b0;
      end
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      dispatch_ready   <= 1'b1;
      commit1_valid    <= 1'b0;
      commit1_rd       <= '0;
      commit1_p_rd     <= '0;
      commit1_p_old_rd <= '0;
      commit2_valid    <= 1'b0;
      commit2_rd       <= '0;
      commit2_p_rd     <= '0;
      commit2_p_old_rd <= '0;
      freed_mask       <= '0;
    end else begin
      // Completions only mark entries that are currently occupied.
      if (complete1_valid && ent_vld[complete1_rob_idx]) ent_done[complete1_rob_idx] <= 1'b1;
      if (complete2_valid && ent_vld[complete2_rob_idx]) ent_done[complete2_rob_idx] <= 1'b1;
      if (ret1) begin
        ent_vld[head]  <= 1'b0;
        ent_done[head] <= 1'b0;
      end
      if (ret2) begin
        ent_vld[head_nx1]  <= 1'b0;
        ent_done[head_nx1] <= 1'b0;
      end
      if (acc1) begin
        ent_vld[dispatch1_rob_idx]      <= 1'b1;
        ent_done[dispatch1_rob_idx]     <= 1'b0;
        ent_rd[dispatch1_rob_idx]       <= dispatch1_rd;
        ent_p_rd[dispatch1_rob_idx]     <= dispatch1_p_rd;
        ent_p_old_rd[dispatch1_rob_idx] <= dispatch1_p_old_rd;
      end
      if (acc2) begin
        ent_vld[dispatch2_rob_idx]      <= 1'b1;
        ent_done[dispatch2_rob_idx]     <= 1'b0;
        ent_rd[dispatch2_rob_idx]       <= dispatch2_rd;
        ent_p_rd[dispatch2_rob_idx]     <= dispatch2_p_rd;
        ent_p_old_rd[dispatch2_rob_idx] <= dispatch2_p_old_rd;
      end
      head             <= head + IW'(num_ret);
      tail             <= tail + IW'(num_acc);
      count            <= count_nxt;
      dispatch_ready   <= (count_nxt <= READY_MAX);
      commit1_valid    <= ret1;
      commit1_rd       <= ret1 ? ent_rd[head]       : 5'd0;
      commit1_p_rd     <= ret1 ? ent_p_rd[head]     : 6'd0;
      commit1_p_old_rd <= ret1 ? ent_p_old_rd[head] : 6'd0;
      commit2_valid    <= ret2;
      commit2_rd       <= ret2 ? ent_rd[head_nx1]       : 5'd0;
      commit2_p_rd     <= ret2 ? ent_p_rd[head_nx1]     : 6'd0;
      commit2_p_old_rd <= ret2 ? ent_p_old_rd[head_nx1] : 6'd0;
      freed_mask       <= freed_nxt;
    end
  end

endmodule
